// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: MEM-stage FSM encoding and bus timeout default
package cpu_pkg;

   // MEM-stage access FSM
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } mau_state_t;

   // Cycles allowed in WAIT without an ack before the access is abandoned
   localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - saturating bus-wait counter with expiry flag
module mem_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Count WAIT cycles; hold at the last value instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store responder on a req/ack data bus
module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_mem_enable,
   input  logic              mem_mem_read,
   input  logic              mem_mem_write,
   input  logic [ADDR_W-1:0] mem_alu_out,
   input  logic [DATA_W-1:0] mem_reg_data_2,
   output logic              stall,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              misalign_err,
   output logic              bus_err,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata
);

   mau_state_t state;

   logic op_valid;
   logic aligned;
   logic tmo_expired;

   assign op_valid = mem_mem_enable & (mem_mem_read | mem_mem_write);
   assign aligned  = (mem_alu_out[1:0] == 2'b00);

   // Reset gates the combinational outputs so they fall in the same cycle as
   // the registered ones, even while the pipeline still presents a valid op.
   assign stall        = ~rst & (((state == IDLE) & op_valid & aligned) | (state == WAIT));
   assign misalign_err = ~rst & (state == IDLE) & op_valid & ~aligned;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == IDLE),
      .enable  (state == WAIT),
      .expired (tmo_expired)
   );

   // Access FSM with registered bus signals and completion pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid && aligned) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_mem_write;
                  dmem_addr  <= {mem_alu_out[ADDR_W-1:2], 2'b00};
                  dmem_wdata <= mem_reg_data_2;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               // An ack on the expiry cycle still completes normally
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (!dmem_we) begin
                     rd_data  <= dmem_rdata;
                     rd_valid <= 1'b1;
                  end
                  state <= DONE;
               end else if (tmo_expired) begin
                  dmem_req <= 1'b0;
                  bus_err  <= 1'b1;
                  if (!dmem_we) begin
                     rd_data  <= '0;
                     rd_valid <= 1'b1;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               // The pipeline advances on this edge, so never issue here
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
